// File: rtl/alu_cmd_pkg.sv
// rtl/alu_cmd_pkg.sv - shared opcodes, FSM encoding, command layout and opcode legality check
package alu_cmd_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_NAND  = 4'b0001;
  localparam logic [3:0] OP_OR    = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_XNOR  = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_NOT   = 4'b0110;
  localparam logic [3:0] OP_ADD   = 4'b0111;
  localparam logic [3:0] OP_SUB   = 4'b1000;
  localparam logic [3:0] OP_MUL   = 4'b1001;
  localparam logic [3:0] OP_SHIFT = 4'b1010;

  localparam int CMD_W = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] opcode;
  } cmd_t;

  function automatic logic is_legal_opcode(input logic [3:0] op);
    return (op <= OP_SHIFT);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - command FIFO; push is refused when full, pop is ignored when empty
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 13
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_pipe.sv
// rtl/alu_cmd_pipe.sv - FIFO-fed register stage around a combinational 4-bit ALU with valid/ready results
// Optional ALU_CMD_STATS_EN adds saturating stat_ops/stat_errs counters.
module alu_cmd_pipe
  import alu_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_a,
  input  logic [3:0]             cmd_b,
  input  logic                   cmd_cin,
  input  logic [3:0]             cmd_opcode,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic                   alu_cin,
  output logic [3:0]             alu_opcode,
  input  logic [3:0]             alu_y,
  input  logic [7:0]             alu_y8,
  input  logic [3:0]             alu_cout,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [7:0]             res_data,
  output logic [3:0]             res_cout,
  output logic [3:0]             res_opcode,
  output logic                   res_err,
`ifdef ALU_CMD_STATS_EN
  output logic [CNTW-1:0]        stat_ops,
  output logic [CNTW-1:0]        stat_errs,
`endif
  output logic [$clog2(DEPTH):0] fifo_count
);

  state_t             state;
  state_t             state_next;
  cmd_t               push_cmd;
  cmd_t               head;
  logic [CMD_W-1:0]   head_bits;
  logic               full;
  logic               empty;
  logic               pop;
  logic               head_legal;

  assign push_cmd   = '{a: cmd_a, b: cmd_b, cin: cmd_cin, opcode: cmd_opcode};
  assign head       = cmd_t'(head_bits);
  assign head_legal = is_legal_opcode(head.opcode);
  assign cmd_ready  = !full;
  assign res_valid  = (state == HOLD);

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_valid),
    .push_data (push_cmd),
    .pop       (pop),
    .pop_data  (head_bits),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = head_legal ? EXEC : HOLD;
        end
      end
      EXEC: state_next = HOLD;
      HOLD: begin
        if (res_ready) begin
          if (!empty) begin
            pop        = 1'b1;
            state_next = head_legal ? EXEC : HOLD;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Illegal opcodes bypass the ALU and leave the alu_* registers untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cin    <= 1'b0;
      alu_opcode <= '0;
      res_data   <= '0;
      res_cout   <= '0;
      res_opcode <= '0;
      res_err    <= 1'b0;
    end else begin
      if (pop && head_legal) begin
        alu_a      <= head.a;
        alu_b      <= head.b;
        alu_cin    <= head.cin;
        alu_opcode <= head.opcode;
      end
      if (state == EXEC) begin
        res_data   <= (alu_opcode == OP_MUL) ? alu_y8 : {4'b0000, alu_y};
        res_cout   <= (alu_opcode == OP_ADD || alu_opcode == OP_SUB) ? alu_cout : 4'b0000;
        res_opcode <= alu_opcode;
        res_err    <= 1'b0;
      end else if (pop && !head_legal) begin
        res_data   <= '0;
        res_cout   <= '0;
        res_opcode <= head.opcode;
        res_err    <= 1'b1;
      end
    end
  end

`ifdef ALU_CMD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops  <= '0;
      stat_errs <= '0;
    end else if (res_valid && res_ready) begin
      if (stat_ops != '1)             stat_ops  <= stat_ops + CNTW'(1);
      if (res_err && stat_errs != '1) stat_errs <= stat_errs + CNTW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_pipe.sv
// tb/tb_alu_cmd_pipe.sv - directed scoreboard bench for alu_cmd_pipe with a behavioural ALU
module tb_alu_cmd_pipe;
  import alu_cmd_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNTW  = 16;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [3:0]             cmd_a;
  logic [3:0]             cmd_b;
  logic                   cmd_cin;
  logic [3:0]             cmd_opcode;
  logic [3:0]             alu_a;
  logic [3:0]             alu_b;
  logic                   alu_cin;
  logic [3:0]             alu_opcode;
  logic [3:0]             alu_y;
  logic [7:0]             alu_y8;
  logic [3:0]             alu_cout;
  logic                   res_valid;
  logic                   res_ready;
  logic [7:0]             res_data;
  logic [3:0]             res_cout;
  logic [3:0]             res_opcode;
  logic                   res_err;
  logic [$clog2(DEPTH):0] fifo_count;
`ifdef ALU_CMD_STATS_EN
  logic [CNTW-1:0]        stat_ops;
  logic [CNTW-1:0]        stat_errs;
`endif

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  logic [16:0] sb_q[$];
  int          hs_cycles[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_cmd_pipe #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_cin    (cmd_cin),
    .cmd_opcode (cmd_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_opcode (alu_opcode),
    .alu_y      (alu_y),
    .alu_y8     (alu_y8),
    .alu_cout   (alu_cout),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_cout   (res_cout),
    .res_opcode (res_opcode),
    .res_err    (res_err),
`ifdef ALU_CMD_STATS_EN
    .stat_ops   (stat_ops),
    .stat_errs  (stat_errs),
`endif
    .fifo_count (fifo_count)
  );

  // Behavioural ALU; cout is deliberately nonzero for ops whose carry must be masked
  always_comb begin
    logic [4:0] s;
    s        = '0;
    alu_y    = '0;
    alu_y8   = {4'b0000, alu_a} * {4'b0000, alu_b};
    alu_cout = 4'hF;
    case (alu_opcode)
      OP_AND:   alu_y = alu_a & alu_b;
      OP_NAND:  alu_y = ~(alu_a & alu_b);
      OP_OR:    alu_y = alu_a | alu_b;
      OP_XOR:   alu_y = alu_a ^ alu_b;
      OP_XNOR:  alu_y = ~(alu_a ^ alu_b);
      OP_NOR:   alu_y = ~(alu_a | alu_b);
      OP_NOT:   alu_y = ~alu_a;
      OP_ADD: begin
        s        = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0000, alu_cin};
        alu_y    = s[3:0];
        alu_cout = {3'b000, s[4]};
      end
      OP_SUB: begin
        s        = {1'b0, alu_a} - {1'b0, alu_b} - {4'b0000, alu_cin};
        alu_y    = s[3:0];
        alu_cout = {3'b000, s[4]};
      end
      OP_MUL:   alu_y = alu_y8[3:0];
      OP_SHIFT: alu_y = alu_a << 1;
      default:  alu_y = 4'h0;
    endcase
  end

  function automatic logic [16:0] exp_result(input logic [3:0] a, input logic [3:0] b,
                                             input logic c, input logic [3:0] op);
    logic [4:0] s;
    logic [7:0] d;
    logic [3:0] co;
    s  = '0;
    d  = '0;
    co = '0;
    if (op > 4'd10) return {1'b1, op, 4'h0, 8'h00};
    case (op)
      4'd0: d = {4'b0000, a & b};
      4'd1: d = {4'b0000, ~(a & b)};
      4'd2: d = {4'b0000, a | b};
      4'd3: d = {4'b0000, a ^ b};
      4'd4: d = {4'b0000, ~(a ^ b)};
      4'd5: d = {4'b0000, ~(a | b)};
      4'd6: d = {4'b0000, ~a};
      4'd7: begin
        s  = {1'b0, a} + {1'b0, b} + {4'b0000, c};
        d  = {4'b0000, s[3:0]};
        co = {3'b000, s[4]};
      end
      4'd8: begin
        s  = {1'b0, a} - {1'b0, b} - {4'b0000, c};
        d  = {4'b0000, s[3:0]};
        co = {3'b000, s[4]};
      end
      4'd9:    d = {4'b0000, a} * {4'b0000, b};
      default: d = {4'b0000, a << 1};
    endcase
    return {1'b0, op, co, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop: outputs are stable from this negedge through the handshake edge
  always @(negedge clk) begin
    if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", {res_err, res_opcode, res_cout, res_data}, 32'hFFFF_FFFF);
      end else begin
        check("result", {res_err, res_opcode, res_cout, res_data}, sb_q.pop_front());
        hs_cycles.push_back(cyc);
      end
    end
  end

  task automatic push_cmd(input logic [3:0] a, input logic [3:0] b, input logic c,
                          input logic [3:0] op, output logic acc);
    cmd_valid  = 1'b1;
    cmd_a      = a;
    cmd_b      = b;
    cmd_cin    = c;
    cmd_opcode = op;
    @(negedge clk);
    acc = cmd_ready;
    if (acc) sb_q.push_back(exp_result(a, b, c, op));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || res_valid) && n < 60) begin
      step(1);
      n++;
    end
    check(tag, (n < 60), 1);
    step(1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    logic [3:0] ops[5];
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_a      = '0;
    cmd_b      = '0;
    cmd_cin    = 1'b0;
    cmd_opcode = '0;
    res_ready  = 1'b0;
    #12;
    check("rst_fifo_count", fifo_count, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_word", {res_err, res_opcode, res_cout, res_data}, 0);
    check("rst_alu_regs", {alu_a, alu_b, alu_cin, alu_opcode}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1);

    // ADD with latency check: push at edge t, EXEC at t+1, res_valid at t+2
    res_ready = 1'b1;
    push_cmd(4'd5, 4'd3, 1'b0, OP_ADD, acc);
    check("add_accept", acc, 1);
    @(negedge clk);
    check("add_lat_t0", res_valid, 0);
    step(1);
    @(negedge clk);
    check("add_lat_t1", res_valid, 0);
    step(1);
    check("add_lat_t2", res_valid, 1);
    check("add_data", res_data, 8'h08);
    check("add_cout", res_cout, 4'h0);
    check("add_err", res_err, 0);
    drain("add_drain");

    push_cmd(4'hF, 4'hF, 1'b0, OP_MUL, acc);
    step(2);
    check("mul_valid", res_valid, 1);
    check("mul_data", res_data, 8'hE1);
    check("mul_opcode", res_opcode, OP_MUL);
    check("mul_cout", res_cout, 4'h0);
    drain("mul_drain");

    // Backpressure: five accepted, sixth refused, then in-order drain every 2 cycles
    res_ready = 1'b0;
    ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_XOR; ops[3] = OP_MUL; ops[4] = OP_NOR;
    for (int i = 0; i < 5; i++) begin
      push_cmd(4'(i + 9), 4'(i * 3 + 4), 1'(i), ops[i], acc);
      check("bp_accept", acc, 1);
    end
    check("bp_count_full", fifo_count, 4);
    check("bp_cmd_ready", cmd_ready, 0);
    check("bp_hold_valid", res_valid, 1);
    check("bp_hold_first", res_opcode, OP_ADD);
    push_cmd(4'd1, 4'd1, 1'b0, OP_AND, acc);
    check("bp_sixth_refused", acc, 0);
    check("bp_count_still", fifo_count, 4);
    hs_cycles.delete();
    res_ready = 1'b1;
    drain("bp_drain");
    check("bp_results", hs_cycles.size(), 5);
    for (int i = 1; i < hs_cycles.size(); i++)
      check("bp_gap", hs_cycles[i] - hs_cycles[i-1], 2);

    // Illegal opcode skips the ALU; next legal command still runs
    push_cmd(4'h3, 4'h4, 1'b1, 4'b1100, acc);
    push_cmd(4'hA, 4'h6, 1'b0, OP_AND, acc);
    check("ill_valid", res_valid, 1);
    check("ill_err", res_err, 1);
    check("ill_data", res_data, 8'h00);
    check("ill_cout", res_cout, 4'h0);
    step(2);
    check("ill_next_data", res_data, 8'h02);
    check("ill_next_err", res_err, 0);
    drain("ill_drain");

    // Reset while in EXEC with two commands queued
    res_ready = 1'b0;
    push_cmd(4'h1, 4'h2, 1'b0, OP_OR, acc);
    push_cmd(4'h5, 4'h9, 1'b0, OP_XNOR, acc);
    push_cmd(4'h6, 4'h0, 1'b0, OP_NOT, acc);
    push_cmd(4'h7, 4'h0, 1'b0, OP_SHIFT, acc);
    res_ready = 1'b1;
    step(1);
    check("rx_pre_count", fifo_count, 2);
    check("rx_pre_exec", res_valid, 0);
    rst_n = 1'b0;
    #1;
    check("rx_count", fifo_count, 0);
    check("rx_cmd_ready", cmd_ready, 1);
    check("rx_res_valid", res_valid, 0);
    check("rx_res_word", {res_err, res_opcode, res_cout, res_data}, 0);
    check("rx_alu_regs", {alu_a, alu_b, alu_cin, alu_opcode}, 0);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(6);
    check("rx_no_stale", res_valid, 0);
    check("rx_count_after", fifo_count, 0);

    // Three legal and one illegal completions after the reset
    push_cmd(4'h2, 4'h3, 1'b0, OP_ADD, acc);
    push_cmd(4'h9, 4'h4, 1'b1, OP_SUB, acc);
    push_cmd(4'h0, 4'h0, 1'b0, 4'b1111, acc);
    push_cmd(4'hC, 4'h5, 1'b0, OP_NAND, acc);
    drain("st_drain");
`ifdef ALU_CMD_STATS_EN
    check("stat_ops", stat_ops, 4);
    check("stat_errs", stat_errs, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_cmd_pipe.md
Name: alu_cmd_pipe

Overview:
Sequential front/back-end stage wrapped around the combinational 4-bit ALU (AND/NAND/OR/XOR/XNOR/NOR/NOT/ADD/SUB/MUL/SHIFT).
- Upstream: buffers ALU commands in a small FIFO.
- ALU side: drives operands and opcode from registers, then captures the ALU outputs one cycle later.
- Downstream: presents one merged result word per command through a valid/ready handshake.

Parameters:
- DEPTH, 4: command FIFO entries; power of 2, minimum 2.
- CNTW, 16: width of the optional statistics counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; high iff FIFO not full.
- cmd_a  in  4  operand A.
- cmd_b  in  4  operand B.
- cmd_cin  in  1  carry/borrow in.
- cmd_opcode  in  4  ALU opcode.
- alu_a  out  4  registered operand A to the ALU.
- alu_b  out  4  registered operand B to the ALU.
- alu_cin  out  1  registered carry in to the ALU.
- alu_opcode  out  4  registered opcode to the ALU.
- alu_y  in  4  ALU 4-bit result.
- alu_y8  in  8  ALU 8-bit result (multiply).
- alu_cout  in  4  ALU carry out.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts.
- res_data  out  8  merged result.
- res_cout  out  4  carry out for ADD/SUB, else 0.
- res_opcode  out  4  opcode of this result.
- res_err  out  1  illegal opcode flag.
- fifo_count  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, rst_n low):
  - FIFO emptied; fifo_count=0; cmd_ready=1.
  - alu_a/alu_b/alu_cin/alu_opcode=0.
  - res_valid=0; res_data/res_cout/res_opcode/res_err=0.
  - FSM=IDLE.
  - Reset mid-operation discards the in-flight command and all queued commands. No result is produced for them.
- FIFO:
  - Push on cmd_valid&&cmd_ready.
  - cmd_ready depends only on registered count. A full FIFO refuses a push even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, EXEC, HOLD.
  - IDLE: if FIFO non-empty, pop the head into the alu_* registers and go to EXEC.
    - If the popped opcode is illegal (1011..1111), the ALU is skipped; go directly to HOLD with res_data=0, res_cout=0, res_err=1.
  - EXEC: exactly one cycle; the ALU settles combinationally. At the next edge, capture into the result registers and go to HOLD with res_valid=1:
    - res_opcode=alu_opcode.
    - res_data={4'b0,alu_y}, or alu_y8 when opcode=1001.
    - res_cout=alu_cout when opcode is 0111 or 1000, else 0.
    - res_err=0.
  - HOLD: res_valid=1; outputs stable until res_valid&&res_ready.
    - On handshake with FIFO non-empty: pop the next command, go to EXEC (or back to HOLD if the opcode is illegal). res_valid drops only when no next result is ready that edge.
    - On handshake with FIFO empty: go to IDLE, res_valid=0.
- alu_* registers hold their last values outside EXEC; they are not cleared.
- Latency: command pushed at edge t reaches EXEC at edge t+1 (if IDLE); res_valid rises at edge t+2.
- Throughput: one result per 2 cycles while res_ready=1.
- A push into an empty FIFO while IDLE is not bypassed; the command is popped the following cycle.

Optional Feature:
ALU_CMD_STATS_EN:
- When defined, adds outputs stat_ops [CNTW-1:0] and stat_errs [CNTW-1:0].
- stat_ops counts completed result handshakes; stat_errs counts those with res_err=1.
- Both counters saturate at all-ones and reset to 0.
- When undefined, these ports and the counters are absent; all other behaviour is identical.

Decomposition:
- Package alu_cmd_pkg, holding:
  - opcode constants: OP_AND=0000 through OP_SHIFT=1010, including OP_ADD=0111, OP_SUB=1000, OP_MUL=1001;
  - the IDLE/EXEC/HOLD state encoding;
  - an is_legal_opcode function.
- One sub-module: alu_cmd_fifo (parameterised DEPTH, width 13: a,b,cin,opcode), exposing push/pop/full/empty/count.

Test Plan:
- ADD: push A=5,B=3,Cin=0,op=0111 with ALU model 8/0000 → res_valid at push+2 cycles; res_data=0x08, res_cout=0, res_err=0.
- MUL: push A=15,B=15,op=1001 with alu_y8=0xE1 → res_data=0xE1, res_opcode=1001, res_cout=0.
- Backpressure: hold res_ready=0 and push 5 commands (DEPTH=4) → fifo_count=4 while HOLD holds the first result; cmd_ready=0 after the 4th queued; 6th push refused; release res_ready → results emerge in order, every 2 cycles.
- Illegal opcode: push op=1100 then op=0000 (A=0xA,B=0x6) → first result res_err=1, res_data=0; second res_data=0x02, res_err=0.
- Reset mid-EXEC: assert rst_n=0 with 2 queued → all outputs 0 immediately (async), fifo_count=0, no stale result after release.
- ALU_CMD_STATS_EN: 3 legal + 1 illegal completed → stat_ops=4, stat_errs=1; with CNTW=2, 5 ops → stat_ops=3 (saturated).
